inst_queue: RTL

- Parametrised instruction buffer between the fetch and decode stages.
- Generalises the single-entry fetch/decode handoff into a DEPTH-entry first-word-fall-through (FWFT) FIFO.
- Adds the following, which the plain handoff lacks:
  - early backpressure to fetch (programmable margin);
  - a flush path for mispredicts and exceptions;
  - an occupancy count;
  - a sticky overflow flag for verification.

---
 rtl/inst_queue_pkg.sv | 15 +
 rtl/inst_queue_ptr.sv | 35 +++
 rtl/inst_queue.sv | 104 ++++++++++
 3 files changed

// File: rtl/inst_queue_pkg.sv
// Shared fetch/decode configuration for the instruction buffer.
package inst_queue_pkg;

    localparam int unsigned AddrWidth       = 32;
    localparam int unsigned InstWidth       = 32;
    localparam int unsigned InstQueueDepth  = 4;
    localparam int unsigned InstQueueMargin = 1;

    // Entry payload as handed between the fetch and decode stages.
    typedef struct packed {
        logic [AddrWidth-1:0] pc;
        logic [InstWidth-1:0] inst;
    } InstQueueEnt_t;

endpackage

// File: rtl/inst_queue_ptr.sv
// Modulo-DEPTH pointer with increment enable and synchronous clear (clear wins).
module inst_queue_ptr #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] ptr_q, ptr_d;

    // Explicit wrap compare so non-power-of-two depths work.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/inst_queue.sv
// DEPTH-entry FWFT instruction buffer between fetch and decode, with early
// backpressure, flush, occupancy count and a sticky overflow flag.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned ADDR   = AddrWidth,
    parameter int unsigned INST   = InstWidth,
    parameter int unsigned DEPTH  = InstQueueDepth,
    parameter int unsigned MARGIN = InstQueueMargin,
    parameter int unsigned CNT    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_,
    input  logic            in_e_,
    input  logic [ADDR-1:0] in_pc,
    input  logic [INST-1:0] in_inst,
    output logic            in_stall,
    output logic            out_e_,
    output logic [ADDR-1:0] out_pc,
    output logic [INST-1:0] out_inst,
    input  logic            out_stall,
    output logic [CNT-1:0]  count,
    output logic            overflow
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [ADDR-1:0] pc_q   [DEPTH];
    logic [INST-1:0] inst_q [DEPTH];

    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CNT-1:0] count_q, count_d;
    logic           overflow_q, overflow_d;

    logic flush, empty, full, pop, push, drop;

    assign flush = !flush_;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT'(DEPTH));
    assign pop   = !empty && !out_stall;
    assign push  = !in_e_ && (!full || pop);
    assign drop  = !in_e_ && full && !pop;

    inst_queue_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clr_i (flush),
        .inc_i (push),
        .ptr_o (wr_ptr)
    );

    inst_queue_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clr_i (flush),
        .inc_i (pop),
        .ptr_o (rd_ptr)
    );

    // Storage is deliberately not reset; only the occupancy decides validity.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_q[wr_ptr]   <= in_pc;
            inst_q[wr_ptr] <= in_inst;
        end
    end

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            count_d = '0;
        end else begin
            if (push && !pop) begin
                count_d = count_q + CNT'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT'(1);
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Free entries <= MARGIN, rewritten as an occupancy threshold.
    assign in_stall = (count_q >= CNT'(DEPTH - MARGIN));
    assign out_e_   = empty;
    assign out_pc   = empty ? '0 : pc_q[rd_ptr];
    assign out_inst = empty ? '0 : inst_q[rd_ptr];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule
